// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, colour-bar codes and the axis-length helper for the VGA generator.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package vga_pkg;

   // Default 640x480@60 raster, 25.175 MHz-class pixel rate
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   // Colour depth per channel and counter widths
   localparam int unsigned DEF_CW = 4;
   localparam int unsigned DEF_XW = 11;
   localparam int unsigned DEF_YW = 10;

   // Colour bars as {R,G,B} on/off flags, left to right across the active line
   localparam logic [2:0] BAR_WHITE   = 3'b111;
   localparam logic [2:0] BAR_YELLOW  = 3'b110;
   localparam logic [2:0] BAR_CYAN    = 3'b011;
   localparam logic [2:0] BAR_GREEN   = 3'b010;
   localparam logic [2:0] BAR_MAGENTA = 3'b101;
   localparam logic [2:0] BAR_RED     = 3'b100;
   localparam logic [2:0] BAR_BLUE    = 3'b001;
   localparam logic [2:0] BAR_BLACK   = 3'b000;

   // Full length of one axis in pixels or lines
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // Colour flags for bar number idx (0 = leftmost)
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] rgb;
      rgb = BAR_BLACK;
      case (idx)
         3'd0: rgb = BAR_WHITE;
         3'd1: rgb = BAR_YELLOW;
         3'd2: rgb = BAR_CYAN;
         3'd3: rgb = BAR_GREEN;
         3'd4: rgb = BAR_MAGENTA;
         3'd5: rgb = BAR_RED;
         3'd6: rgb = BAR_BLUE;
         default: rgb = BAR_BLACK;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-request and VGA pin bundle between the timing generator (master) and its neighbours (slave).
// Latency: none (wiring only). testpat exists only when VGA_TESTPAT_EN is defined.
// Backpressure: none; the raster never stalls, pix_ce only paces it.
interface vga_timing_gen_if
   import vga_pkg::*;
#(
   parameter int unsigned CW = DEF_CW,
   parameter int unsigned XW = DEF_XW,
   parameter int unsigned YW = DEF_YW
);
   logic            pix_ce;
   logic [3*CW-1:0] pixel_in;
`ifdef VGA_TESTPAT_EN
   logic            testpat;
`endif
   logic [XW-1:0]   req_x;
   logic [YW-1:0]   req_y;
   logic            req_valid;
   logic            hsync;
   logic            vsync;
   logic            de;
   logic [CW-1:0]   red;
   logic [CW-1:0]   green;
   logic [CW-1:0]   blue;
   logic            frame_start;
   logic            line_start;

   modport master (
      input  pix_ce,
      input  pixel_in,
`ifdef VGA_TESTPAT_EN
      input  testpat,
`endif
      output req_x,
      output req_y,
      output req_valid,
      output hsync,
      output vsync,
      output de,
      output red,
      output green,
      output blue,
      output frame_start,
      output line_start
   );

   modport slave (
      output pix_ce,
      output pixel_in,
`ifdef VGA_TESTPAT_EN
      output testpat,
`endif
      input  req_x,
      input  req_y,
      input  req_valid,
      input  hsync,
      input  vsync,
      input  de,
      input  red,
      input  green,
      input  blue,
      input  frame_start,
      input  line_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, active-area and sync-region decode.
// Latency: count updates on the edge where i_adv=1; decodes are combinational from the count.
// Backpressure: none; i_adv=0 simply holds the position.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned W      = DEF_XW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_adv,
   output logic [W-1:0] o_count,
   output logic         o_wrap,
   output logic         o_active,
   output logic         o_sync_region
);
   localparam int unsigned           TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
   localparam longint unsigned       CAPACITY = 64'd1 << W;
   localparam logic [W-1:0]          LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0]          ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0]          SYNC_BEG = W'(ACTIVE + FP);
   localparam logic [W-1:0]          SYNC_END = W'(ACTIVE + FP + SYNC);

   // The whole axis, including the terminal count, must fit the counter
   if (64'(TOTAL) >= CAPACITY) begin : g_width_check
      $error("vga_axis_counter: axis total %0d does not fit in %0d bits", TOTAL, W);
   end

   logic [W-1:0] r_count;

   // Position counter: steps on each enabled cycle, returns to 0 after the last position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_adv) begin
         r_count <= o_wrap ? '0 : r_count + W'(1);
      end
   end

   assign o_count       = r_count;
   assign o_wrap        = (r_count == LAST);
   assign o_active      = (r_count < ACT_END);
   assign o_sync_region = (r_count >= SYNC_BEG) && (r_count < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with registered sync/de/RGB pins; optional colour bars under VGA_TESTPAT_EN.
// Latency: pins lag the req_x/req_y position by one pix_ce; frame_start/line_start are one clk wide.
// Backpressure: none; pix_ce=0 freezes counters and pins, pulses still clear on the next clk.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned CW       = DEF_CW,
   parameter int unsigned XW       = DEF_XW,
   parameter int unsigned YW       = DEF_YW
) (
   input  logic            clk,
   input  logic            rst_n,
   vga_timing_gen_if.master bus
);
   logic [XW-1:0]   w_hcnt;
   logic [YW-1:0]   w_vcnt;
   logic            w_h_wrap;
   logic            w_h_active;
   logic            w_h_sync;
   logic            w_v_adv;
   logic            w_v_wrap;
   logic            w_v_active;
   logic            w_v_sync;
   logic            w_req_valid;
   logic            w_origin;
   logic [3*CW-1:0] w_pix;
   logic            w_unused;

   logic            r_hsync;
   logic            r_vsync;
   logic            r_de;
   logic [3*CW-1:0] r_rgb;
   logic            r_frame_start;
   logic            r_line_start;

   // The vertical axis steps once per line, on the enabled cycle that ends it
   assign w_v_adv = bus.pix_ce & w_h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .W      (XW)
   ) u_h_axis (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_adv         (bus.pix_ce),
      .o_count       (w_hcnt),
      .o_wrap        (w_h_wrap),
      .o_active      (w_h_active),
      .o_sync_region (w_h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .W      (YW)
   ) u_v_axis (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_adv         (w_v_adv),
      .o_count       (w_vcnt),
      .o_wrap        (w_v_wrap),
      .o_active      (w_v_active),
      .o_sync_region (w_v_sync)
   );

   // End-of-frame is implied by both counters returning to zero; nothing downstream needs it
   assign w_unused = w_v_wrap;

   assign w_req_valid   = w_h_active & w_v_active;
   assign w_origin      = (w_hcnt == '0) && (w_vcnt == '0);
   assign bus.req_x     = w_hcnt;
   assign bus.req_y     = w_vcnt;
   assign bus.req_valid = w_req_valid;

`ifdef VGA_TESTPAT_EN
   // Eight equal bars; narrow rasters fall back to 1-pixel bars and the tail stays on the last bar
   localparam int unsigned BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

   logic [XW-1:0] w_bar_idx;
   logic [2:0]    w_bar_flags;

   assign w_bar_idx   = w_hcnt / XW'(BAR_W);
   assign w_bar_flags = bar_rgb((w_bar_idx > XW'(7)) ? 3'd7 : w_bar_idx[2:0]);
   assign w_pix       = bus.testpat ? {{CW{w_bar_flags[2]}}, {CW{w_bar_flags[1]}}, {CW{w_bar_flags[0]}}}
                                    : bus.pixel_in;
`else
   assign w_pix = bus.pixel_in;
`endif

   // Pin stage: capture the current position's sync/de/colour on pix_ce; pulses drop on the next clk regardless
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync       <= ~H_POL;
         r_vsync       <= ~V_POL;
         r_de          <= 1'b0;
         r_rgb         <= '0;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end else if (bus.pix_ce) begin
         r_hsync       <= w_h_sync ? H_POL : ~H_POL;
         r_vsync       <= w_v_sync ? V_POL : ~V_POL;
         r_de          <= w_req_valid;
         r_rgb         <= w_req_valid ? w_pix : '0;
         r_frame_start <= w_origin;
         r_line_start  <= (w_hcnt == '0);
      end else begin
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end
   end

   assign bus.hsync       = r_hsync;
   assign bus.vsync       = r_vsync;
   assign bus.de          = r_de;
   assign bus.red         = r_rgb[3*CW-1:2*CW];
   assign bus.green       = r_rgb[2*CW-1:CW];
   assign bus.blue        = r_rgb[CW-1:0];
   assign bus.frame_start = r_frame_start;
   assign bus.line_start  = r_line_start;

endmodule
